class_merge: RTL and testbench
==============================

CLASS_MERGE -- requirements
Module: class_merge

Interface
REQ-001 Parameter DATA_SIZE, default 10, SHALL set word width in bits.
REQ-002 Parameter MAIN_SIZE, default 8, SHALL set payload width; bits [DATA_SIZE-1:MAIN_SIZE] are the tag and pass through unmodified.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of 2), SHALL set the entries per class FIFO.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 push_0  input  1  SHALL be the class-0 write request.
REQ-007 push_1  input  1  SHALL be the class-1 write request.
REQ-008 in0  input  DATA_SIZE  SHALL be the class-0 write data.
REQ-009 in1  input  DATA_SIZE  SHALL be the class-1 write data.
REQ-010 almost_full  input  1  SHALL be downstream backpressure; 1 = do not send.
REQ-011 out  output  DATA_SIZE  SHALL be the merged output word (registered).
REQ-012 valid_out  output  1  SHALL mark out as valid for exactly the cycle it is held (registered).
REQ-013 out_class  output  1  SHALL give the source class of out (registered).
REQ-014 fifo_empty0, fifo_empty1  output  1 each  SHALL flag the corresponding FIFO as empty.
REQ-015 fifo_full0, fifo_full1  output  1 each  SHALL flag the corresponding FIFO as full.
REQ-016 Error  output  1  SHALL be the sticky overflow flag.

Function
REQ-017 Each class SHALL own a FIFO_DEPTH-entry FIFO with wrapping read/write pointers and a count of width log2(FIFO_DEPTH)+1.
REQ-018 A push SHALL write inX at the write pointer when the FIFO is not full, or when it is full and popped in the same cycle (count unchanged).
REQ-019 A push to a full FIFO not popped that cycle SHALL drop the word, leave pointers and count unchanged, and set Error on that edge.
REQ-020 Arbiter FSM states SHALL be IDLE, GRANT0, GRANT1; the state records the last grant.
REQ-021 Pop SHALL be allowed only when almost_full=0; otherwise no pop occurs, valid_out<=0, and the state holds.
REQ-022 With pop allowed and only one FIFO non-empty, that FIFO SHALL be popped and the state SHALL go to its GRANTx.
REQ-023 With both FIFOs non-empty, IDLE or GRANT1 SHALL grant class 0 and GRANT0 SHALL grant class 1 (round-robin).
REQ-024 With both FIFOs empty, valid_out<=0 and the state SHALL hold (IDLE stays IDLE).
REQ-025 On a pop: out<=head word, out_class<=class, valid_out<=1, read pointer +1 mod FIFO_DEPTH, count -1 (unless a same-cycle push occurs).
REQ-026 When valid_out=0, out and out_class SHALL retain their last values.
REQ-027 Latency: a word pushed into an empty FIFO at edge k SHALL appear on out with valid_out=1 after edge k+1, provided almost_full=0 and the word wins arbitration.
REQ-028 Empty/full flags SHALL be decoded combinationally from the counts (count==0, count==FIFO_DEPTH).
REQ-029 Words of one class SHALL leave in push order; no word SHALL be duplicated or lost except on an overflow drop.
REQ-030 Arbitration SHALL use the pre-edge counts; a word pushed in the same cycle SHALL not be poppable in that cycle.

Reset
REQ-031 While reset=1, asynchronously: pointers and counts 0, state IDLE, out=0, out_class=0, valid_out=0, Error=0, fifo_empty0/1=1, fifo_full0/1=0.
REQ-032 Reset asserted mid-operation SHALL discard all stored words; no valid_out SHALL occur until a new push.

Verification
REQ-033 Reset, then push_0 with in0=0x155 for one cycle -> valid_out=1, out=0x155, out_class=0 on the next cycle; then fifo_empty0=1.
REQ-034 Fill both FIFOs (class 0: 0x001-0x004; class 1: 0x101-0x104) while almost_full=1, then release -> output order 0x001,0x101,0x002,0x102,... with valid_out high for 8 consecutive cycles.
REQ-035 With class 0 full, push 0x3FF while not popping -> Error=1 stays set, 0x3FF is never output, and fifo_full0 stays 1.
REQ-036 With class 0 full and pop allowed, push 0x2AA in the same cycle -> no Error, count stays 4, and 0x2AA is output fifth.
REQ-037 Raise almost_full while words are pending -> valid_out=0 from the next edge and out holds its last value; lower it -> output resumes with the next word in round-robin order.
REQ-038 Assert reset with 3 words stored -> all outputs at reset values immediately; after release, valid_out stays 0 until the next push.

Source files
------------

// File: rtl/class_merge.sv
// class_merge: merges two classed word streams through per-class FIFOs
// into one registered output using round-robin arbitration.
//   clk, reset            : clock, asynchronous active-high reset
//   push_0/in0, push_1/in1: per-class write request and data
//   almost_full           : downstream backpressure, 1 = do not send
//   out/out_class/valid_out: registered merged word, its class and valid
//   fifo_empty0/1, fifo_full0/1: per-class FIFO status
//   Error                 : sticky overflow flag (push dropped on full FIFO)
module class_merge #(
    parameter int DATA_SIZE  = 10,
    parameter int MAIN_SIZE  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_0,
    input  logic                 push_1,
    input  logic [DATA_SIZE-1:0] in0,
    input  logic [DATA_SIZE-1:0] in1,
    input  logic                 almost_full,
    output logic [DATA_SIZE-1:0] out,
    output logic                 valid_out,
    output logic                 out_class,
    output logic                 fifo_empty0,
    output logic                 fifo_empty1,
    output logic                 fifo_full0,
    output logic                 fifo_full1,
    output logic                 Error
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t state, next_state;
    logic [1:0] push, pop, empty, full, ovf;
    logic [DATA_SIZE-1:0] din [2];
    logic [DATA_SIZE-1:0] head [2];
    logic [DATA_SIZE-1:0] sel;
    assign push = {push_1, push_0};
    assign din[0] = in0;
    assign din[1] = in1;
    assign fifo_empty0 = empty[0];
    assign fifo_empty1 = empty[1];
    assign fifo_full0 = full[0];
    assign fifo_full1 = full[1];
    for (genvar c = 0; c < 2; c++) begin : g_fifo
        logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr, rd_ptr;
        logic [PW:0] count;
        logic wr;
        assign empty[c] = count == '0;
        assign full[c] = count == (PW+1)'(FIFO_DEPTH);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        assign wr = push[c] && (!full[c] || pop[c]);
        assign ovf[c] = push[c] && full[c] && !pop[c];
        assign head[c] = mem[rd_ptr];
        always_ff @(posedge clk)
            if (wr) mem[wr_ptr] <= din[c];
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (wr) wr_ptr <= wr_ptr + 1'b1;
                if (pop[c]) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PW+1)'(wr) - (PW+1)'(pop[c]);
            end
    end
    // Arbitration looks only at pre-edge counts, so a word pushed this
    // cycle cannot be popped until the next one.
    always_comb begin
        pop = 2'b00;
        next_state = state;
        if (!almost_full) begin
            if (!empty[0] && (empty[1] || state != GRANT0)) pop = 2'b01;
            else if (!empty[1]) pop = 2'b10;
            next_state = pop[0] ? GRANT0 : pop[1] ? GRANT1 : state;
        end
    end
    assign sel = pop[1] ? head[1] : head[0];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            out <= '0;
            out_class <= 1'b0;
            valid_out <= 1'b0;
            Error <= 1'b0;
        end else begin
            state <= next_state;
            valid_out <= |pop;
            Error <= Error | (|ovf);
            if (|pop) begin
                out <= {sel[DATA_SIZE-1:MAIN_SIZE], sel[MAIN_SIZE-1:0]};
                out_class <= pop[1];
            end
        end
endmodule

// File: tb/tb_class_merge.sv
// tb_class_merge: directed vector table plus hand sequences for class_merge.
module tb_class_merge;
    logic clk = 1'b0;
    logic reset, push_0, push_1, almost_full;
    logic [9:0] in0, in1, out;
    logic valid_out, out_class, fifo_empty0, fifo_empty1, fifo_full0, fifo_full1, Error;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    class_merge dut (
        .clk(clk), .reset(reset), .push_0(push_0), .push_1(push_1),
        .in0(in0), .in1(in1), .almost_full(almost_full), .out(out),
        .valid_out(valid_out), .out_class(out_class),
        .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
        .fifo_full0(fifo_full0), .fifo_full1(fifo_full1), .Error(Error)
    );

    // flags field order: {empty0, empty1, full0, full1}
    typedef struct {
        logic       p0;
        logic [9:0] d0;
        logic       p1;
        logic [9:0] d1;
        logic       af;
        logic       v;
        logic       c;
        logic [3:0] fl;
        logic       err;
        logic [9:0] o;
    } vec_t;

    vec_t tbl [17];
    logic [9:0] w36 [5];
    logic [9:0] w35 [4];

    function automatic logic [16:0] snap();
        return {valid_out, out_class, fifo_empty0, fifo_empty1, fifo_full0, fifo_full1, Error, out};
    endfunction

    function automatic logic [16:0] ex(input logic v, input logic c, input logic [3:0] fl,
                                       input logic err, input logic [9:0] o);
        return {v, c, fl, err, o};
    endfunction

    task automatic chk(input string nm, input logic [16:0] req);
        logic [16:0] act;
        act = snap();
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual={v,c,e0,e1,f0,f1,err,out}=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step(input logic p0, input logic [9:0] d0, input logic p1,
                        input logic [9:0] d1, input logic af);
        push_0 = p0;
        in0 = d0;
        push_1 = p1;
        in1 = d1;
        almost_full = af;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic af);
        step(1'b0, 10'h000, 1'b0, 10'h000, af);
    endtask

    initial begin
        tbl = '{
            '{1'b1, 10'h155, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 10'h000},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 4'b1100, 1'b0, 10'h155},
            '{1'b0, 10'h000, 1'b1, 10'h0AB, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 10'h155},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 10'h0AB},
            '{1'b1, 10'h001, 1'b1, 10'h101, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 10'h0AB},
            '{1'b1, 10'h002, 1'b1, 10'h102, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 10'h0AB},
            '{1'b1, 10'h003, 1'b1, 10'h103, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 10'h0AB},
            '{1'b1, 10'h004, 1'b1, 10'h104, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b0, 10'h0AB},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 10'h001},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h101},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h002},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h102},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h003},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h103},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 10'h004},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 10'h104},
            '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 10'h104}
        };
        w36 = '{10'h021, 10'h022, 10'h023, 10'h024, 10'h2AA};
        w35 = '{10'h011, 10'h012, 10'h013, 10'h014};
        reset = 1'b1;
        push_0 = 1'b0;
        push_1 = 1'b0;
        in0 = '0;
        in1 = '0;
        almost_full = 1'b0;
        #12;
        chk("reset_state", ex(1'b0, 1'b0, 4'b1100, 1'b0, 10'h000));
        reset = 1'b0;
        // single push latency, class-1 path, fill under backpressure, round-robin drain
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].p0, tbl[i].d0, tbl[i].p1, tbl[i].d1, tbl[i].af);
            chk($sformatf("vec%0d", i), {tbl[i].v, tbl[i].c, tbl[i].fl, tbl[i].err, tbl[i].o});
        end
        // full FIFO pushed while popping: accepted, count stays at depth
        for (int i = 0; i < 4; i++) begin
            step(1'b1, w36[i], 1'b0, 10'h000, 1'b1);
            chk($sformatf("fill36_%0d", i), ex(1'b0, 1'b1, (i == 3) ? 4'b0110 : 4'b0100, 1'b0, 10'h104));
        end
        step(1'b1, 10'h2AA, 1'b0, 10'h000, 1'b0);
        chk("push_pop_full", ex(1'b1, 1'b0, 4'b0110, 1'b0, 10'h021));
        for (int i = 1; i < 5; i++) begin
            idle(1'b0);
            chk($sformatf("drain36_%0d", i), ex(1'b1, 1'b0, (i == 4) ? 4'b1100 : 4'b0100, 1'b0, w36[i]));
        end
        idle(1'b0);
        chk("drain36_end", ex(1'b0, 1'b0, 4'b1100, 1'b0, 10'h2AA));
        // backpressure mid-stream holds out, then round-robin resumes
        step(1'b1, 10'h031, 1'b1, 10'h131, 1'b1);
        chk("bp_fill0", ex(1'b0, 1'b0, 4'b0000, 1'b0, 10'h2AA));
        step(1'b1, 10'h032, 1'b1, 10'h132, 1'b1);
        chk("bp_fill1", ex(1'b0, 1'b0, 4'b0000, 1'b0, 10'h2AA));
        idle(1'b0);
        chk("bp_out_131", ex(1'b1, 1'b1, 4'b0000, 1'b0, 10'h131));
        idle(1'b0);
        chk("bp_out_031", ex(1'b1, 1'b0, 4'b0000, 1'b0, 10'h031));
        idle(1'b1);
        chk("bp_hold0", ex(1'b0, 1'b0, 4'b0000, 1'b0, 10'h031));
        idle(1'b1);
        chk("bp_hold1", ex(1'b0, 1'b0, 4'b0000, 1'b0, 10'h031));
        idle(1'b0);
        chk("bp_out_132", ex(1'b1, 1'b1, 4'b0100, 1'b0, 10'h132));
        idle(1'b0);
        chk("bp_out_032", ex(1'b1, 1'b0, 4'b1100, 1'b0, 10'h032));
        idle(1'b0);
        chk("bp_end", ex(1'b0, 1'b0, 4'b1100, 1'b0, 10'h032));
        // overflow: dropped word, sticky Error
        for (int i = 0; i < 4; i++) begin
            step(1'b1, w35[i], 1'b0, 10'h000, 1'b1);
            chk($sformatf("fill35_%0d", i), ex(1'b0, 1'b0, (i == 3) ? 4'b0110 : 4'b0100, 1'b0, 10'h032));
        end
        step(1'b1, 10'h3FF, 1'b0, 10'h000, 1'b1);
        chk("overflow", ex(1'b0, 1'b0, 4'b0110, 1'b1, 10'h032));
        idle(1'b1);
        chk("overflow_sticky", ex(1'b0, 1'b0, 4'b0110, 1'b1, 10'h032));
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk($sformatf("drain35_%0d", i), ex(1'b1, 1'b0, (i == 3) ? 4'b1100 : 4'b0100, 1'b1, w35[i]));
        end
        idle(1'b0);
        chk("drain35_end", ex(1'b0, 1'b0, 4'b1100, 1'b1, 10'h014));
        // reset with stored words discards them
        step(1'b1, 10'h041, 1'b1, 10'h141, 1'b1);
        chk("pre_rst0", ex(1'b0, 1'b0, 4'b0000, 1'b1, 10'h014));
        step(1'b1, 10'h042, 1'b0, 10'h000, 1'b1);
        chk("pre_rst1", ex(1'b0, 1'b0, 4'b0000, 1'b1, 10'h014));
        push_0 = 1'b0;
        almost_full = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", ex(1'b0, 1'b0, 4'b1100, 1'b0, 10'h000));
        @(posedge clk);
        #1;
        chk("reset_held", ex(1'b0, 1'b0, 4'b1100, 1'b0, 10'h000));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk($sformatf("post_rst_%0d", i), ex(1'b0, 1'b0, 4'b1100, 1'b0, 10'h000));
        end
        step(1'b1, 10'h055, 1'b0, 10'h000, 1'b0);
        chk("post_rst_push", ex(1'b0, 1'b0, 4'b0100, 1'b0, 10'h000));
        idle(1'b0);
        chk("post_rst_out", ex(1'b1, 1'b0, 4'b1100, 1'b0, 10'h055));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
